// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK demodulator: carrier mix, 16-sample integrate-and-dump,
// hard-decision slicer and a single-entry AXIS output register.
module psk_demod #(
    parameter int WIDTH = 12,
    parameter int BYTES = 1
) (
    input  logic                    clk_16M384,
    input  logic                    rst_16M384,
    input  logic signed [WIDTH-1:0] in_I,
    input  logic signed [WIDTH-1:0] in_Q,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic                    in_is_bpsk,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    input  logic [3:0]              DELAY_CNT,
    output logic [BYTES*8-1:0]      out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tlast,
    output logic                    out_tuser,
    output logic                    overflow
);
    localparam int XW = 2 * WIDTH;
    localparam int PW = 2 * WIDTH + 1;
    localparam int AW = 2 * WIDTH + 5;
    localparam int DW = 2 * WIDTH + 6;
    localparam int TW = BYTES * 8;

    logic [3:0]        cnt_q, cnt_d;

    logic signed [XW-1:0] in_i_x, in_q_x, car_i_x, car_q_x;
    logic signed [XW-1:0] p_ii, p_qq, p_qi, p_iq;
    logic [PW-1:0]     prod_d [2];
    logic [PW-1:0]     prod_q [2];
    logic              start_d, start_q, vld_d, vld_q;
    logic              last_d, last_q, bpsk_d, bpsk_q;

    logic [AW-1:0]     add_x [2];
    logic [AW-1:0]     acc_d [2];
    logic [AW-1:0]     acc_q [2];
    logic [4:0]        scnt_d, scnt_q;
    logic              all_vld_d, all_vld_q, any_last_d, any_last_q;
    logic              win_bpsk_d, win_bpsk_q;

    logic [AW-1:0]     cl_d [2];
    logic [AW-1:0]     cl_q [2];
    logic              close_d, close_q, cl_last_d, cl_last_q, cl_bpsk_d, cl_bpsk_q;

    logic [DW-1:0]     sum_a, dif_b;
    logic              neg_a, neg_b;
    logic [1:0]        sym;

    logic              accept;
    logic              out_vld_d, out_vld_q, out_last_d, out_last_q;
    logic              out_user_d, out_user_q, ovf_d, ovf_q;
    logic [TW-1:0]     out_data_d, out_data_q;

    assign in_i_x  = {{WIDTH{in_I[WIDTH-1]}}, in_I};
    assign in_q_x  = {{WIDTH{in_Q[WIDTH-1]}}, in_Q};
    assign car_i_x = {{WIDTH{carrier_I[WIDTH-1]}}, carrier_I};
    assign car_q_x = {{WIDTH{carrier_Q[WIDTH-1]}}, carrier_Q};
    assign p_ii    = in_i_x * car_i_x;
    assign p_qq    = in_q_x * car_q_x;
    assign p_qi    = in_q_x * car_i_x;
    assign p_iq    = in_i_x * car_q_x;

    // Stage 1: complex multiply by the conjugate carrier, flags ride along.
    always_comb begin
        cnt_d     = cnt_q + 4'd1;
        prod_d[0] = {p_ii[XW-1], p_ii} + {p_qq[XW-1], p_qq};
        prod_d[1] = {p_qi[XW-1], p_qi} - {p_iq[XW-1], p_iq};
        start_d   = (cnt_q == DELAY_CNT);
        vld_d     = in_vld;
        last_d    = in_last;
        bpsk_d    = in_is_bpsk;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign add_x[gi] = {{(AW - PW){prod_q[gi][PW-1]}}, prod_q[gi]};
        end
    endgenerate

    // Stage 2: a start-flagged product closes the old window and seeds the new one.
    always_comb begin
        close_d   = 1'b0;
        cl_last_d = cl_last_q;
        cl_bpsk_d = cl_bpsk_q;
        for (int i = 0; i < 2; i++) begin
            cl_d[i]  = cl_q[i];
            acc_d[i] = acc_q[i] + add_x[i];
        end
        scnt_d     = (scnt_q == 5'd31) ? scnt_q : scnt_q + 5'd1;
        all_vld_d  = all_vld_q & vld_q;
        any_last_d = any_last_q | last_q;
        win_bpsk_d = win_bpsk_q;
        if (start_q) begin
            close_d   = (scnt_q == 5'd16) && all_vld_q;
            cl_last_d = any_last_q;
            cl_bpsk_d = win_bpsk_q;
            for (int i = 0; i < 2; i++) begin
                cl_d[i]  = acc_q[i];
                acc_d[i] = add_x[i];
            end
            scnt_d     = 5'd1;
            all_vld_d  = vld_q;
            any_last_d = last_q;
            win_bpsk_d = bpsk_q;
        end
    end

    assign sum_a = {cl_q[0][AW-1], cl_q[0]} + {cl_q[1][AW-1], cl_q[1]};
    assign dif_b = {cl_q[0][AW-1], cl_q[0]} - {cl_q[1][AW-1], cl_q[1]};
    assign neg_a = 1'(sum_a >> (DW - 1));
    assign neg_b = 1'(dif_b >> (DW - 1));
    assign sym   = cl_bpsk_q ? {~cl_q[0][AW-1], 1'b0} : {neg_a, neg_b};

    // Output register: a decision arriving while full and not drained is dropped.
    always_comb begin
        accept     = out_vld_q & out_tready;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_user_d = out_user_q;
        ovf_d      = ovf_q;
        if (close_q) begin
            if (!out_vld_q || accept) begin
                out_vld_d  = 1'b1;
                out_data_d = {{(TW - 2){1'b0}}, sym};
                out_last_d = cl_last_q;
                out_user_d = cl_bpsk_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (accept) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            cnt_q      <= '0;
            start_q    <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            bpsk_q     <= 1'b0;
            scnt_q     <= '0;
            all_vld_q  <= 1'b0;
            any_last_q <= 1'b0;
            win_bpsk_q <= 1'b0;
            close_q    <= 1'b0;
            cl_last_q  <= 1'b0;
            cl_bpsk_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
                cl_q[i]   <= '0;
            end
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_user_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            bpsk_q     <= bpsk_d;
            scnt_q     <= scnt_d;
            all_vld_q  <= all_vld_d;
            any_last_q <= any_last_d;
            win_bpsk_q <= win_bpsk_d;
            close_q    <= close_d;
            cl_last_q  <= cl_last_d;
            cl_bpsk_q  <= cl_bpsk_d;
            for (int i = 0; i < 2; i++) begin
                prod_q[i] <= prod_d[i];
                acc_q[i]  <= acc_d[i];
                cl_q[i]   <= cl_d[i];
            end
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_user_q <= out_user_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_tdata  = out_data_q;
    assign out_tvalid = out_vld_q;
    assign out_tlast  = out_last_q;
    assign out_tuser  = out_user_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_psk_demod.sv
// Randomized bench for psk_demod; a window-level integer model predicts every
// symbol, its timing, the holding-register behaviour and the overflow flag.
module tb_psk_demod;
    localparam int W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in_I, in_Q, carrier_I, carrier_Q;
    logic                in_vld, in_last, in_is_bpsk;
    logic [3:0]          DELAY_CNT;
    logic [7:0]          out_tdata;
    logic                out_tvalid, out_tready, out_tlast, out_tuser, overflow;

    always #5 clk = ~clk;

    psk_demod #(.WIDTH(W), .BYTES(1)) dut (
        .clk_16M384 (clk),
        .rst_16M384 (rst),
        .in_I       (in_I),
        .in_Q       (in_Q),
        .in_vld     (in_vld),
        .in_last    (in_last),
        .in_is_bpsk (in_is_bpsk),
        .carrier_I  (carrier_I),
        .carrier_Q  (carrier_Q),
        .DELAY_CNT  (DELAY_CNT),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .out_tuser  (out_tuser),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    typedef struct {
        int due;
        int sym;
        bit last;
        bit bpsk;
    } dec_t;

    dec_t   pend[$];
    int     m_cnt, m_n, edge_no, n_xfer;
    bit     m_win_ok, m_allv, m_anyl, m_bpsk;
    longint m_re, m_im;
    bit     mo_v, mo_last, mo_bpsk, mo_ovf;
    int     mo_sym;
    int     pt_idx = 0;
    bit     bpsk_sel = 1'b0;
    int     pts_i [4] = '{1000, 0, -1000, 0};
    int     pts_q [4] = '{0, -1000, 0, 1000};

    function automatic int decide(input longint re, input longint im, input bit bpsk);
        if (bpsk)
            return (re >= 0) ? 2 : 0;
        return ((re + im < 0) ? 2 : 0) + ((re - im < 0) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_n = 0; m_win_ok = 1'b0; m_allv = 1'b0; m_anyl = 1'b0;
        m_bpsk = 1'b0; m_re = 0; m_im = 0;
        pend.delete();
        mo_v = 1'b0; mo_sym = 0; mo_last = 1'b0; mo_bpsk = 1'b0; mo_ovf = 1'b0;
    endtask

    task automatic model_edge();
        bit     acc, has, st;
        dec_t   d;
        longint pr, pi;
        if (rst) begin
            model_reset();
            edge_no++;
            return;
        end
        acc = mo_v && out_tready;
        if (acc) begin
            n_xfer++;
            $display("xfer %0d: sym=%0d last=%0d bpsk=%0d", n_xfer, mo_sym, mo_last, mo_bpsk);
        end
        has = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_no) begin
            d = pend.pop_front();
            has = 1'b1;
        end
        if (has) begin
            if (!mo_v || acc) begin
                mo_v = 1'b1; mo_sym = d.sym; mo_last = d.last; mo_bpsk = d.bpsk;
            end else begin
                mo_ovf = 1'b1;
            end
        end else if (acc) begin
            mo_v = 1'b0;
        end
        st = (m_cnt == int'(DELAY_CNT));
        m_cnt = (m_cnt + 1) % 16;
        pr = longint'(in_I) * longint'(carrier_I) + longint'(in_Q) * longint'(carrier_Q);
        pi = longint'(in_Q) * longint'(carrier_I) - longint'(in_I) * longint'(carrier_Q);
        if (st) begin
            // the window just ended had its last sample one edge ago; output 3 edges after that
            if (m_win_ok && m_n == 16 && m_allv) begin
                d.due = edge_no + 2; d.sym = decide(m_re, m_im, m_bpsk);
                d.last = m_anyl; d.bpsk = m_bpsk;
                pend.push_back(d);
            end
            m_win_ok = 1'b1; m_re = pr; m_im = pi; m_n = 1;
            m_allv = in_vld; m_anyl = in_last; m_bpsk = in_is_bpsk;
        end else begin
            m_re += pr; m_im += pi; m_n++;
            m_allv &= in_vld; m_anyl |= in_last;
        end
        edge_no++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_val("tvalid", longint'(out_tvalid), longint'(mo_v));
        if (mo_v) begin
            check_val("tdata", longint'(out_tdata), longint'(mo_sym));
            check_val("tlast", longint'(out_tlast), longint'(mo_last));
            check_val("tuser", longint'(out_tuser), longint'(mo_bpsk));
        end
        check_val("overflow", longint'(overflow), longint'(mo_ovf));
        if (rst) begin
            check_val("rst_tdata", longint'(out_tdata), 0);
            check_val("rst_tlast", longint'(out_tlast), 0);
            check_val("rst_tuser", longint'(out_tuser), 0);
        end
    endtask

    task automatic drive(input int mode);
        int nz_i, nz_q;
        case (mode)
            0: begin
                in_is_bpsk = 1'b1; carrier_I = 1000; carrier_Q = 0;
                in_I = 1000; in_Q = 0; in_vld = 1'b1; in_last = 1'b0;
            end
            1: begin
                if (m_cnt == int'(DELAY_CNT)) pt_idx = (pt_idx + 1) % 4;
                in_is_bpsk = 1'b0; carrier_I = 1000; carrier_Q = 0;
                in_I = W'(pts_i[pt_idx]); in_Q = W'(pts_q[pt_idx]);
                in_vld = 1'b1; in_last = 1'b0;
            end
            2: begin
                if (m_cnt == int'(DELAY_CNT)) begin
                    pt_idx = int'($urandom_range(0, 3));
                    bpsk_sel = 1'($urandom_range(0, 1));
                end
                nz_i = int'($urandom_range(0, 600)) - 300;
                nz_q = int'($urandom_range(0, 600)) - 300;
                in_is_bpsk = ($urandom_range(0, 9) == 0) ? ~bpsk_sel : bpsk_sel;
                carrier_I = 1000; carrier_Q = 0;
                in_I = W'(pts_i[pt_idx] + nz_i); in_Q = W'(pts_q[pt_idx] + nz_q);
                in_vld = ($urandom_range(0, 29) != 0);
                in_last = ($urandom_range(0, 19) == 0);
            end
            3: begin
                if (m_cnt == int'(DELAY_CNT)) bpsk_sel = 1'($urandom_range(0, 1));
                in_is_bpsk = bpsk_sel; carrier_I = W'($urandom); carrier_Q = W'($urandom);
                in_I = 0; in_Q = 0; in_vld = 1'b1; in_last = 1'b0;
            end
            default: begin
                in_is_bpsk = 1'($urandom_range(0, 1));
                carrier_I = W'($urandom); carrier_Q = W'($urandom);
                in_I = W'($urandom); in_Q = W'($urandom);
                in_vld = ($urandom_range(0, 15) != 0);
                in_last = ($urandom_range(0, 9) == 0);
            end
        endcase
    endtask

    task automatic run(input int n, input int mode, input int rdy_mode);
        for (int k = 0; k < n; k++) begin
            drive(mode);
            case (rdy_mode)
                0:       out_tready = 1'b0;
                1:       out_tready = 1'b1;
                default: out_tready = ($urandom_range(0, 3) != 0);
            endcase
            tick();
        end
    endtask

    initial begin
        edge_no = 0;
        n_xfer = 0;
        model_reset();
        rst = 1'b1;
        DELAY_CNT = 4'd3;
        out_tready = 1'b1;
        drive(0);
        run(4, 0, 1);
        rst = 1'b0;

        run(100, 0, 1);
        run(160, 1, 1);
        run(320, 2, 2);
        run(8, 0, 1);
        run(40, 0, 0);
        run(40, 0, 1);
        DELAY_CNT = 4'd7;
        run(80, 0, 1);
        run(64, 3, 1);
        run(25, 0, 0);
        rst = 1'b1;
        run(1, 0, 1);
        rst = 1'b0;
        run(60, 0, 1);
        for (int r = 0; r < 3; r++) begin
            DELAY_CNT = 4'($urandom_range(0, 15));
            run(200, 4, 2);
        end
        run(64, 2, 1);
        check_val("xfers_seen", longint'(n_xfer > 40), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_demod.md
Name: psk_demod

Overview:
BPSK/QPSK coherent demodulator and symbol slicer, the receive-side counterpart of the PSK modulator.
- Mixes received I/Q samples with the local carrier at 16.384 MHz.
- Integrates and dumps over 16-sample symbol windows, with window phase set by DELAY_CNT.
- Makes hard bit decisions and delivers one symbol per window on an AXIS master toward the RX byte-packing FIFO.

Parameters:
WIDTH, 12, sample and carrier width (signed).
BYTES, 1, AXIS tdata width in bytes (minimum 1).

Ports:
clk_16M384  in  1  system clock.
rst_16M384  in  1  synchronous reset, active-high.
in_I  in  WIDTH  received I sample, signed.
in_Q  in  WIDTH  received Q sample, signed.
in_vld  in  1  sample valid.
in_last  in  1  frame-end marker on the sample stream.
in_is_bpsk  in  1  1 = BPSK, 0 = QPSK.
carrier_I  in  WIDTH  local cos, signed.
carrier_Q  in  WIDTH  local sin, signed.
DELAY_CNT  in  4  window phase: a window starts on the cycle where cnt == DELAY_CNT.
out_tdata  out  BYTES*8  bits [1:0] carry the decided symbol; upper bits are 0.
out_tvalid  out  1  AXIS valid.
out_tready  in  1  AXIS ready.
out_tlast  out  1  window contained in_last.
out_tuser  out  1  is_bpsk of the symbol.
overflow  out  1  sticky flag: a decided symbol was dropped.

Behaviour:
- cnt: 4-bit free-running counter, reset to 0, increments every cycle and wraps 15→0.
- Stage 1 (registered products, 1 cycle):
  - re = in_I*carrier_I + in_Q*carrier_Q
  - im = in_Q*carrier_I − in_I*carrier_Q
  - Width 2*WIDTH+1.
  - Window bookkeeping flags travel with the products: start = (cnt == DELAY_CNT), in_vld, in_last, in_is_bpsk.
- Stage 2 (accumulate):
  - Accumulators acc_re and acc_im are 2*WIDTH+5 bits, sign-extended, and cannot overflow over 16 samples.
  - A 5-bit sample counter counts samples in the current window.
  - all_vld is the AND of in_vld over the window.
  - any_last is the OR of in_last over the window.
  - is_bpsk is captured from the window's first sample.
  - When a start-flagged product arrives, the previous window closes and is sent to the decision stage. In the same cycle the accumulators load that product, which begins the new window.
- Window qualification: a closed window is decided only if sample count == 16 and all_vld == 1. Otherwise it is discarded silently.
  - The first window after reset is always partial and therefore discarded.
  - A change of DELAY_CNT produces one short or long window, which is discarded; windows after that are clean.
- Decision (registered), with A = acc_re + acc_im and B = acc_re − acc_im (2*WIDTH+6 bits):
  - BPSK: bit1 = (acc_re >= 0), bit0 = 0.
  - QPSK: bit1 = (A < 0), bit0 = (B < 0). This maps 1 → 00, −j → 10, −1 → 11, +j → 01 (Gray, matching the TX constellation).
  - An exact zero resolves as non-negative.
- Latency: the decided symbol is presented on out_tvalid/out_tdata 3 clock edges after the edge that samples the window's last input sample. The edges are product, close, and decision/output register.
- Output holding register, single entry:
  - Loads a new symbol when empty, or when the current symbol is accepted (out_tvalid & out_tready) in the same cycle as the new decision.
  - If it is full and not accepted on the cycle a new decision arrives, the new symbol is dropped, the held symbol is kept, and overflow is set until reset.
  - out_tvalid stays high until accepted. tdata, tlast and tuser are stable while valid and not ready.
- Reset: all outputs are 0, including out_tvalid, out_tdata, out_tlast, out_tuser and overflow. Accumulators, counters, flags and cnt are cleared. Reset asserted mid-window or with a pending output discards everything, and no symbol is emitted for the interrupted window.

Test Plan:
1. WIDTH=12, DELAY_CNT=3, carrier_I=1000, carrier_Q=0, BPSK, in_I=+1000, in_Q=0 held, in_vld=1, out_tready=1 -> first window discarded, then one symbol every 16 cycles with tdata=0x02 and tuser=1; acc_re=16,000,000 (internal probe).
2. Same setup but QPSK, driving (in_I,in_Q) = (1000,0), (0,−1000), (−1000,0), (0,1000) for one window each -> tdata 0x00, 0x02, 0x03, 0x01 in order, tuser=0, and out_tvalid rises 3 edges after each window's last sample.
3. Drop in_vld for 1 cycle mid-window -> that symbol is absent, neighbouring symbols are intact, overflow stays 0.
4. out_tready=0 for 40 cycles across 3 windows -> the first symbol is held stable, the next two are dropped, overflow=1; after ready returns, the held symbol transfers once.
5. Pulse in_last on sample 9 of a window -> that symbol has out_tlast=1 and all others have 0. Change DELAY_CNT 3→7 mid-stream -> exactly one symbol lost, then 0x02 symbols resume.
6. Assert rst_16M384 at sample 8 of a window with one symbol pending -> all outputs are 0 the next cycle and no stale symbol is emitted after release.
